// File: rtl/aq_dcache_line_rd_seq.sv
// Victim-line read sequencer: arbitrates for the data array, issues eight 64-bit reads,
// buffers the 1-cycle-latency SRAM output in a 2-entry FIFO and streams beats out.
// Optional macro AQ_DCACHE_LINE_RD_CRIT_FIRST_EN starts the line at req_dw_idx.
module aq_dcache_line_rd_seq (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [6:0]  req_line_idx,
    input  logic [2:0]  req_dw_idx,
    output logic        arb_req,
    input  logic        arb_gnt,
    output logic        data_cen,
    output logic        data_gwen,
    output logic [63:0] data_wen,
    output logic [63:0] data_din,
    output logic [13:0] data_idx,
    output logic        data_clk_en,
    input  logic [63:0] data_dout,
    output logic        dout_vld,
    input  logic        dout_rdy,
    output logic [63:0] dout_data,
    output logic [2:0]  dout_beat,
    output logic        dout_last
);

    typedef enum logic [1:0] {IDLE, RD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [6:0]  line_q;
    logic [2:0]  beat_q;
    logic [3:0]  issue_cnt;
    logic        inflight;
    logic [2:0]  infl_beat;
    logic        infl_last;
    logic [63:0] buf_data [2];
    logic [2:0]  buf_beat [2];
    logic [1:0]  buf_last;
    logic        rd_ptr, wr_ptr;
    logic [1:0]  buf_cnt;
    logic        issue, push, pop, credit_ok, drained;
    logic [2:0]  start_beat;

`ifdef AQ_DCACHE_LINE_RD_CRIT_FIRST_EN
    assign start_beat = req_dw_idx;
`else
    logic unused_dw_idx;
    assign unused_dw_idx = ^req_dw_idx;
    assign start_beat    = 3'd0;
`endif

    assign push      = inflight;
    assign dout_vld  = (buf_cnt != 2'd0);
    assign pop       = dout_vld & dout_rdy;
    // Buffer slots plus the read in flight never exceed 2, unless a slot frees this cycle.
    assign credit_ok = (({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd2) | pop;
    assign drained   = !inflight && ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop));

    always_comb begin
        state_nxt = state;
        req_rdy   = 1'b0;
        arb_req   = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_vld) state_nxt = RD;
            end
            RD: begin
                arb_req = 1'b1;
                issue   = arb_gnt & credit_ok;
                if (issue && issue_cnt == 4'd7) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drained) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign data_cen    = ~issue;
    assign data_gwen   = 1'b1;
    assign data_wen    = '1;
    assign data_din    = '0;
    assign data_idx    = {1'b0, line_q, beat_q, 3'b000};
    assign data_clk_en = (state != IDLE);

    assign dout_data = buf_data[rd_ptr];
    assign dout_beat = buf_beat[rd_ptr];
    assign dout_last = buf_last[rd_ptr];

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state     <= IDLE;
            line_q    <= '0;
            beat_q    <= '0;
            issue_cnt <= '0;
            inflight  <= 1'b0;
            infl_beat <= '0;
            infl_last <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (state == IDLE && req_vld) begin
                line_q    <= req_line_idx;
                beat_q    <= start_beat;
                issue_cnt <= '0;
            end else if (issue) begin
                beat_q    <= beat_q + 3'd1;
                issue_cnt <= issue_cnt + 4'd1;
            end
            if (issue) begin
                infl_beat <= beat_q;
                infl_last <= (issue_cnt == 4'd7);
            end
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_beat[i] <= '0;
            end
            buf_last <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            buf_cnt  <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= data_dout;
                buf_beat[wr_ptr] <= infl_beat;
                buf_last[wr_ptr] <= infl_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_aq_dcache_line_rd_seq.sv
// Bench for aq_dcache_line_rd_seq: table of line reads plus hand sequences for reset and held requests.
module tb_aq_dcache_line_rd_seq;

`ifdef AQ_DCACHE_LINE_RD_CRIT_FIRST_EN
    localparam bit CRIT_EN = 1'b1;
`else
    localparam bit CRIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        cpurst = 1'b1;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [6:0]  req_line_idx = '0;
    logic [2:0]  req_dw_idx = '0;
    logic        arb_req;
    logic        arb_gnt = 1'b1;
    logic        data_cen, data_gwen, data_clk_en;
    logic [63:0] data_wen, data_din;
    logic [13:0] data_idx;
    logic [63:0] data_dout = '0;
    logic        dout_vld;
    logic        dout_rdy = 1'b1;
    logic [63:0] dout_data;
    logic [2:0]  dout_beat;
    logic        dout_last;

    aq_dcache_line_rd_seq dut (
        .forever_cpuclk(clk), .cpurst(cpurst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_line_idx(req_line_idx), .req_dw_idx(req_dw_idx),
        .arb_req(arb_req), .arb_gnt(arb_gnt),
        .data_cen(data_cen), .data_gwen(data_gwen), .data_wen(data_wen), .data_din(data_din),
        .data_idx(data_idx), .data_clk_en(data_clk_en), .data_dout(data_dout),
        .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout_data(dout_data),
        .dout_beat(dout_beat), .dout_last(dout_last)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [63:0] sram_fn(input logic [13:0] a);
        return {a, 18'h2A5A5, ~a, 18'h13C3C};
    endfunction

    always @(posedge clk) if (!data_cen) data_dout <= sram_fn(data_idx);

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  beat;
        logic        last;
    } beat_t;

    typedef struct {
        logic [6:0]  line;
        logic [2:0]  dw;
        logic [31:0] gnt;
        logic [31:0] rdy;
        int          exp_idle;
        int          exp_last;
    } vec_t;

    beat_t       exp_q[$];
    logic [13:0] iss_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_cyc = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_line(input logic [6:0] line, input logic [2:0] dw);
        logic [2:0]  b;
        logic [13:0] idx;
        beat_t       e;
        b = CRIT_EN ? dw : 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = {1'b0, line, b, 3'b000};
            iss_q.push_back(idx);
            e.data = sram_fn(idx);
            e.beat = b;
            e.last = (i == 7);
            exp_q.push_back(e);
            b = b + 3'd1;
        end
    endtask

    // Scoreboard / protocol monitor, sampled mid-cycle
    logic        stall_chk = 1'b0;
    logic [63:0] prev_data;
    logic [2:0]  prev_beat;
    always @(negedge clk) begin
        beat_t       e;
        logic [13:0] ei;
        if (cpurst) begin
            stall_chk = 1'b0;
        end else begin
            if (!data_cen) begin
                tests++;
                if (iss_q.size() == 0) begin
                    fails++;
                    $display("FAIL issue_unexpected: got idx %0h expected no access", data_idx);
                end else begin
                    ei = iss_q.pop_front();
                    if (data_idx !== ei || arb_gnt !== 1'b1 || arb_req !== 1'b1) begin
                        fails++;
                        $display("FAIL issue_idx: got %0h gnt %0b expected %0h gnt 1", data_idx, arb_gnt, ei);
                    end
                end
            end
            if (stall_chk) begin
                tests++;
                if (dout_vld !== 1'b1 || dout_data !== prev_data || dout_beat !== prev_beat) begin
                    fails++;
                    $display("FAIL stall_hold: got vld %0b data %0h expected vld 1 data %0h", dout_vld, dout_data, prev_data);
                end
            end
            if (dout_vld && dout_rdy) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got beat %0d expected none", dout_beat);
                end else begin
                    e = exp_q.pop_front();
                    if (dout_data !== e.data || dout_beat !== e.beat || dout_last !== e.last) begin
                        fails++;
                        $display("FAIL beat: got %0h/%0d/%0b expected %0h/%0d/%0b",
                                 dout_data, dout_beat, dout_last, e.data, e.beat, e.last);
                    end
                end
                if (dout_last) last_cyc = cyc;
            end
            stall_chk = dout_vld && !dout_rdy;
            prev_data = dout_data;
            prev_beat = dout_beat;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        req_vld  = 1'b0;
        arb_gnt  = 1'b1;
        dout_rdy = 1'b1;
        @(negedge clk);
        while (!(req_rdy && exp_q.size() == 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("idle_timeout", 64'(n), 64'd0);
    endtask

    task automatic run_case(input vec_t v, input string nm);
        int idle_c;
        idle_c   = -1;
        last_cyc = -1;
        wait_idle();
        @(posedge clk); #1;
        req_vld = 1'b1; req_line_idx = v.line; req_dw_idx = v.dw;
        arb_gnt = v.gnt[0]; dout_rdy = v.rdy[0];
        cyc = 0;
        push_line(v.line, v.dw);
        for (int c = 0; c < 60 && idle_c < 0; c++) begin
            @(negedge clk);
            if (c > 0 && req_rdy) idle_c = c;
            @(posedge clk); #1;
            cyc     = c + 1;
            req_vld = 1'b0;
            arb_gnt  = (c + 1 < 32) ? v.gnt[c+1] : 1'b1;
            dout_rdy = (c + 1 < 32) ? v.rdy[c+1] : 1'b1;
        end
        chk({nm, "_idle_cycle"}, 64'(idle_c), 64'(v.exp_idle));
        chk({nm, "_last_cycle"}, 64'(last_cyc), 64'(v.exp_last));
        chk({nm, "_queues_empty"}, 64'(exp_q.size() + iss_q.size()), 64'd0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_req_rdy"}, 64'(req_rdy), 64'd1);
        chk({nm, "_arb_req"}, 64'(arb_req), 64'd0);
        chk({nm, "_data_cen"}, 64'(data_cen), 64'd1);
        chk({nm, "_data_gwen"}, 64'(data_gwen), 64'd1);
        chk({nm, "_data_wen"}, data_wen, '1);
        chk({nm, "_data_din"}, data_din, 64'd0);
        chk({nm, "_data_idx"}, 64'(data_idx), 64'd0);
        chk({nm, "_clk_en"}, 64'(data_clk_en), 64'd0);
        chk({nm, "_dout_vld"}, 64'(dout_vld), 64'd0);
        chk({nm, "_dout_data"}, dout_data, 64'd0);
        chk({nm, "_dout_beat"}, 64'(dout_beat), 64'd0);
        chk({nm, "_dout_last"}, 64'(dout_last), 64'd0);
    endtask

    vec_t vecs [4];

    initial begin
        int acc;
        vecs[0] = '{line: 7'h55, dw: 3'd0, gnt: 32'hFFFF_FFFF, rdy: 32'hFFFF_FFFF, exp_idle: 11, exp_last: 10};
        vecs[1] = '{line: 7'h2A, dw: 3'd0, gnt: 32'hFFFF_FFE3, rdy: 32'hFFFF_FFFF, exp_idle: 14, exp_last: 13};
        vecs[2] = '{line: 7'h7F, dw: 3'd0, gnt: 32'hFFFF_FFFF, rdy: 32'hFFFF_FC0F, exp_idle: 17, exp_last: 16};
        vecs[3] = '{line: 7'h13, dw: 3'd6, gnt: 32'hFFFF_FFFF, rdy: 32'hFFFF_FFFF, exp_idle: 11, exp_last: 10};

        #2;
        chk_reset_vals("por");
        @(posedge clk); #1;
        cpurst = 1'b0;

        for (int i = 0; i < 4; i++) run_case(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-line at cycle 5
        wait_idle();
        @(posedge clk); #1;
        req_vld = 1'b1; req_line_idx = 7'h31; req_dw_idx = 3'd0;
        push_line(7'h31, 3'd0);
        @(posedge clk); #1;
        req_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cpurst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        exp_q.delete();
        iss_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("midrst_cen_held", 64'(data_cen), 64'd1);
        end
        @(posedge clk); #1;
        cpurst = 1'b0;
        run_case(vecs[0], "postrst");

        // req_vld held across a line: second line only in first IDLE cycle
        wait_idle();
        @(posedge clk); #1;
        req_vld = 1'b1; req_line_idx = 7'h0A; req_dw_idx = 3'd0;
        push_line(7'h0A, 3'd0);
        acc = -1;
        for (int c = 0; c < 40 && acc < 0; c++) begin
            @(negedge clk);
            if (c > 0 && req_rdy) begin
                acc = c;
                push_line(7'h0B, 3'd0);
            end
            @(posedge clk); #1;
            cyc = c + 1;
            req_line_idx = 7'h0B;
        end
        req_vld = 1'b0;
        chk("held_accept_cycle", 64'(acc), 64'd11);
        wait_idle();
        chk("held_queues_empty", 64'(exp_q.size() + iss_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
